chrono_ctrl: RTL and testbench
==============================

# chrono_ctrl

Control sequencer for the stopwatch counter datapath. Conditions two raw push-buttons (start/stop, lap/reset), runs the start/stop/lap/clear state machine, and produces the 1 ms count-enable tick, clear pulse and display-freeze level that drive the ms/sec/min/hs counter chain and its display register. Sits between the board buttons and the chronometer counter, in the same clock domain.

## Interface
- CLK_DIV, 50000: clk cycles per 1 ms tick (≥2)
- DEBOUNCE, 20000: consecutive stable cycles required before a button level is accepted (≥1)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- btn_ss  in  1  raw start/stop button, asynchronous, active-high
- btn_lr  in  1  raw lap/reset button, asynchronous, active-high
- tick  out  1  1-cycle count enable to counter, once per CLK_DIV cycles while counting
- clr  out  1  1-cycle synchronous clear to counter
- freeze  out  1  level, display register holds lap value while 1
- running  out  1  level, 1 in RUN and LAP
- state  out  2  current state: 0 IDLE, 1 RUN, 2 STOP, 3 LAP

## Operation
- Per button: 2-flop synchronizer, then debouncer. Debounced level db toggles after sync output differs from db on DEBOUNCE consecutive edges; any agreeing cycle reloads the counter. Press event = one-cycle pulse on db 0→1; release ignored.
- State machine (ss = start/stop event, lr = lap/reset event):
  - IDLE: ss → RUN; lr → IDLE, no effect.
  - RUN: ss → STOP; lr → LAP (freeze=1, counting continues).
  - LAP: lr → RUN (freeze=0); ss → STOP (freeze=0, counting halts).
  - STOP: ss → RUN (resume); lr → IDLE with clr pulse.
- Simultaneous ss and lr events in same cycle: ss wins, lr dropped.
- Prescaler pre, width clog2(CLK_DIV): increments each cycle in RUN/LAP; wraps CLK_DIV-1→0 and asserts tick in that cycle. Holds value in STOP (sub-ms phase preserved across pause). Cleared to 0 on reset and on STOP→IDLE.
- tick never asserts in IDLE or STOP, nor in the same cycle as clr.
- Outputs registered; running, freeze are decoded from the state register.

## Timing
- Reset values: state=IDLE(0), tick=0, clr=1, freeze=0, running=0, pre=0, synchronizers/db=0, debounce counters=0. clr drops on first edge with rst low.
- rst mid-operation: next edge forces all reset values regardless of state or pending events; in-flight debounce discarded.
- Button latency: btn rises and stays high, first sampled on edge E0 → sync high after E1 → db high after E1+DEBOUNCE → event cycle → state register updates at edge E0+DEBOUNCE+3.
- Glitch shorter than DEBOUNCE cycles at sync output: no event.
- First tick after IDLE→RUN: asserted in the CLK_DIV-th cycle in RUN (pre counts 0..CLK_DIV-1).
- Resume after STOP: first tick after (CLK_DIV − pre_held) RUN cycles.
- clr: exactly one cycle, the cycle state first reads IDLE after STOP.
- freeze rises in the first LAP cycle and falls in the first cycle after leaving LAP.

## Test plan
- Reset: hold rst 3 cycles with both buttons high → state=0, clr=1, tick=0, freeze=0; rst low → clr=0 after one edge, no events until buttons released and re-pressed.
- Start and tick rate (CLK_DIV=4, DEBOUNCE=3): press btn_ss → state=1 exactly 6 edges after first sample; tick pulses every 4th cycle, first in 4th RUN cycle; 10 ticks in 40 cycles.
- Pause/resume phase: stop when pre=2 → state=2, no ticks for 50 cycles; restart → first tick 2 RUN cycles after entry.
- Lap: in RUN press btn_lr → state=3, freeze=1, ticks continue at same rate; press btn_lr again → state=1, freeze=0; press btn_ss in LAP → state=2, freeze=0.
- Clear: in STOP press btn_lr → state=0, clr high exactly 1 cycle, pre=0; btn_lr in IDLE → no change, no clr.
- Debounce/priority: 2-cycle pulse on btn_ss → no transition; btn_ss and btn_lr rise same cycle in RUN → state=2, no LAP, no clr.

Source files
------------

// File: rtl/chrono_if.sv
// chrono_if: button inputs and counter-control outputs of the stopwatch sequencer.
interface chrono_if;
   logic       btn_ss;
   logic       btn_lr;
   logic       tick;
   logic       clr;
   logic       freeze;
   logic       running;
   logic [1:0] state;
   modport master (output btn_ss, btn_lr, input tick, clr, freeze, running, state);
   modport slave  (input btn_ss, btn_lr, output tick, clr, freeze, running, state);
endinterface

// File: rtl/chrono_ctrl.sv
// chrono_ctrl: button conditioning, start/stop/lap/clear FSM and 1 ms tick prescaler.
// chrono_btn: per-button synchronizer, debouncer and press-event generator.
module chrono_btn #(
   parameter int DEBOUNCE = 20000
) (
   input  logic clk,
   input  logic rst,
   input  logic vld,
   input  logic btn,
   output logic ev
);
   localparam int DW = $clog2(DEBOUNCE + 1);
   localparam logic [DW-1:0] LAST = DW'(DEBOUNCE - 1);
   logic          s1, s2, db, db_q, armed;
   logic [DW-1:0] cnt, acnt;
   // a button held through reset must be seen released before its presses count
   always_ff @(posedge clk)
      if (rst) begin
         {s1, s2, db, db_q, armed, ev} <= '0;
         cnt <= '0;
         acnt <= '0;
      end else begin
         s1 <= btn;
         s2 <= s1;
         db_q <= db;
         ev <= armed & db & ~db_q;
         cnt <= (s2 == db || cnt == LAST) ? '0 : cnt + 1'b1;
         if (s2 != db && cnt == LAST) db <= s2;
         acnt <= (!vld || s2 || db || acnt == LAST) ? '0 : acnt + 1'b1;
         if (vld && !s2 && !db && acnt == LAST) armed <= 1'b1;
      end
endmodule

module chrono_ctrl #(
   parameter int CLK_DIV  = 50000,
   parameter int DEBOUNCE = 20000
) (
   input logic     clk,
   input logic     rst,
   chrono_if.slave bus
);
   localparam int PW = $clog2(CLK_DIV);
   localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOP = 2'd2, LAP = 2'd3} state_t;
   state_t        st, st_n;
   logic [PW-1:0] pre, pre_n;
   logic [1:0]    vld;
   logic          ev_ss, ev_lr, ss, lr, tick_q, clr_q, run_c, run_n;
   // synchronizer outputs are meaningless for the first two cycles after reset
   always_ff @(posedge clk)
      vld <= rst ? 2'b00 : {vld[0], 1'b1};
   chrono_btn #(.DEBOUNCE(DEBOUNCE)) u_ss (
      .clk(clk), .rst(rst), .vld(vld[1]), .btn(bus.btn_ss), .ev(ev_ss)
   );
   chrono_btn #(.DEBOUNCE(DEBOUNCE)) u_lr (
      .clk(clk), .rst(rst), .vld(vld[1]), .btn(bus.btn_lr), .ev(ev_lr)
   );
   always_comb begin
      ss = ev_ss;
      lr = ev_lr & ~ev_ss;
      st_n = st;
      case (st)
         IDLE: st_n = ss ? RUN : IDLE;
         RUN:  st_n = ss ? STOP : lr ? LAP : RUN;
         LAP:  st_n = ss ? STOP : lr ? RUN : LAP;
         STOP: st_n = ss ? RUN : lr ? IDLE : STOP;
      endcase
      run_c = st == RUN || st == LAP;
      run_n = st_n == RUN || st_n == LAP;
      pre_n = run_c ? (pre == PRE_LAST ? '0 : pre + 1'b1) :
              (st == STOP && st_n == IDLE) ? '0 : pre;
   end
   always_ff @(posedge clk)
      if (rst) begin
         st <= IDLE;
         pre <= '0;
         tick_q <= 1'b0;
         clr_q <= 1'b1;
      end else begin
         st <= st_n;
         pre <= pre_n;
         tick_q <= run_n && pre_n == PRE_LAST;
         clr_q <= st == STOP && st_n == IDLE;
      end
   assign bus.tick    = tick_q;
   assign bus.clr     = clr_q;
   assign bus.state   = st;
   assign bus.running = st == RUN || st == LAP;
   assign bus.freeze  = st == LAP;
endmodule

// File: tb/tb_chrono_ctrl.sv
// tb_chrono_ctrl: randomized button stimulus checked cycle-by-cycle against an event-level model.
module tb_chrono_ctrl;
  localparam int CLK_DIV  = 4;
  localparam int DEBOUNCE = 3;
  localparam int MAXC     = 20000;
  localparam int LAT      = DEBOUNCE + 3;
  typedef struct packed {
    logic [1:0] st;
    logic       tick;
    logic       clr;
    logic       frz;
    logic       run;
  } obs_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  chrono_if bus();
  chrono_ctrl #(.CLK_DIV(CLK_DIV), .DEBOUNCE(DEBOUNCE)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  obs_t       q[$];
  obs_t       exp_o, act_o;
  bit         ev_ss[MAXC];
  bit         ev_lr[MAXC];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         w = 0;
  logic [1:0] m_st = 2'd0;
  logic [1:0] m_ns;
  int         m_pre = 0;
  bit         m_clr, m_ss, m_lr, m_run;
  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_st = 2'd0;
      m_pre = 0;
      m_clr = 1'b1;
    end else begin
      m_ss = cyc < MAXC && ev_ss[cyc];
      m_lr = cyc < MAXC && ev_lr[cyc] && !m_ss;
      m_clr = 1'b0;
      if (m_st == 2'd1 || m_st == 2'd3) m_pre = (m_pre + 1) % CLK_DIV;
      m_ns = m_st;
      case (m_st)
        2'd0: if (m_ss) m_ns = 2'd1;
        2'd1: m_ns = m_ss ? 2'd2 : m_lr ? 2'd3 : 2'd1;
        2'd3: m_ns = m_ss ? 2'd2 : m_lr ? 2'd1 : 2'd3;
        2'd2: if (m_ss) m_ns = 2'd1;
              else if (m_lr) begin m_ns = 2'd0; m_pre = 0; m_clr = 1'b1; end
      endcase
      m_st = m_ns;
    end
    m_run = m_st == 2'd1 || m_st == 2'd3;
    q.push_back({m_st, m_run && m_pre == CLK_DIV - 1, m_clr, m_st == 2'd3, m_run});
  end
  initial forever begin
    @(negedge clk);
    if (q.size() > 0) begin
      exp_o = q.pop_front();
      act_o = {bus.state, bus.tick, bus.clr, bus.freeze, bus.running};
      checks++;
      if (act_o !== exp_o) begin
        errors++;
        $display("FAIL cyc %0d outputs {state,tick,clr,freeze,running}: got %b_%b%b%b%b expected %b_%b%b%b%b",
                 cyc, act_o.st, act_o.tick, act_o.clr, act_o.frz, act_o.run,
                 exp_o.st, exp_o.tick, exp_o.clr, exp_o.frz, exp_o.run);
      end
    end
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic press(input bit s, input bit l, input int hold);
    if (s) bus.btn_ss = 1'b1;
    if (l) bus.btn_lr = 1'b1;
    if (hold >= DEBOUNCE && cyc + 1 + LAT < MAXC) begin
      if (s) ev_ss[cyc + 1 + LAT] = 1'b1;
      if (l) ev_lr[cyc + 1 + LAT] = 1'b1;
    end
    step(hold);
    bus.btn_ss = 1'b0;
    bus.btn_lr = 1'b0;
    step(DEBOUNCE + 3);
  endtask
  initial begin
    bus.btn_ss = 1'b1;
    bus.btn_lr = 1'b1;
    rst = 1'b1;
    step(3);
    checks++;
    if ({bus.state, bus.tick, bus.clr, bus.freeze, bus.running} !== 6'b00_0100) begin
      errors++;
      $display("FAIL reset state: got %b_%b%b%b%b", bus.state, bus.tick, bus.clr, bus.freeze, bus.running);
    end
    rst = 1'b0;
    step(15);
    bus.btn_ss = 1'b0;
    bus.btn_lr = 1'b0;
    step(15);
    press(1, 0, DEBOUNCE + 1);
    w = 0;
    while (!bus.tick && w < 20) begin
      step(1);
      w++;
    end
    checks++;
    if (!bus.tick) begin
      errors++;
      $display("FAIL cyc %0d timeout waiting for tick after start", cyc);
    end
    step(45 - w);
    press(1, 0, DEBOUNCE);
    step(50);
    press(1, 0, DEBOUNCE);
    step(10);
    press(0, 1, DEBOUNCE);
    step(12);
    press(0, 1, DEBOUNCE);
    step(8);
    press(0, 1, DEBOUNCE);
    press(1, 0, DEBOUNCE);
    press(0, 1, DEBOUNCE);
    press(0, 1, DEBOUNCE);
    press(1, 0, DEBOUNCE - 1);
    press(1, 0, DEBOUNCE);
    step(7);
    press(1, 1, DEBOUNCE);
    step(5);
    for (int i = 0; i < 300 && cyc < MAXC - 200; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: press(1, 0, $urandom_range(DEBOUNCE, DEBOUNCE + 4));
        4, 5, 6:    press(0, 1, $urandom_range(DEBOUNCE, DEBOUNCE + 4));
        7:          press(1, 1, $urandom_range(DEBOUNCE, DEBOUNCE + 4));
        8:          press($urandom_range(0, 1) == 1, 1'b1, $urandom_range(1, DEBOUNCE - 1));
        default:    step($urandom_range(1, 30));
      endcase
      if (i == 150) begin
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(12);
      end
    end
    step(5);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
